// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with write-back select, stall/flush
// control and a saturating retired-instruction counter for FPGA bring-up.
module mem_wb_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             stall,
  input  logic             flush,
  input  logic             validIn,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      readData,
  input  logic [4:0]       writeRegIn,
  input  logic             regWriteF,
  input  logic             memToRegF,
  output logic [31:0]      writeData,
  output logic [4:0]       writeRegOut,
  output logic             regWriteOut,
  output logic             validOut,
  output logic [CNT_W-1:0] retiredCount
);

  localparam logic [CNT_W-1:0] CountMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CountOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_q, valid_d;
  logic             regWrite_q, regWrite_d;
  logic [31:0]      writeData_q, writeData_d;
  logic [4:0]       writeReg_q, writeReg_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             loadEdge;
  logic [31:0]      selectedData;

  assign loadEdge     = !flush && !stall;
  assign selectedData = memToRegF ? readData : ALUResult;

  // Next-state: flush empties the slot, stall holds everything, otherwise load.
  always_comb begin
    valid_d     = valid_q;
    regWrite_d  = regWrite_q;
    writeData_d = writeData_q;
    writeReg_d  = writeReg_q;
    count_d     = count_q;
    if (flush) begin
      valid_d     = 1'b0;
      regWrite_d  = 1'b0;
      writeData_d = 32'd0;
      writeReg_d  = 5'd0;
    end else if (!stall) begin
      valid_d     = validIn;
      regWrite_d  = regWriteF && validIn && (writeRegIn != 5'd0);
      writeData_d = selectedData;
      writeReg_d  = writeRegIn;
    end
    if (loadEdge && validIn && (count_q != CountMax)) begin
      count_d = count_q + CountOne;
    end
  end

  // State registers, cleared immediately by the asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      valid_q     <= 1'b0;
      regWrite_q  <= 1'b0;
      writeData_q <= 32'd0;
      writeReg_q  <= 5'd0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      regWrite_q  <= regWrite_d;
      writeData_q <= writeData_d;
      writeReg_q  <= writeReg_d;
      count_q     <= count_d;
    end
  end

  assign writeData    = writeData_q;
  assign writeRegOut  = writeReg_q;
  assign validOut     = valid_q;
  assign regWriteOut  = regWrite_q && valid_q;
  assign retiredCount = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed bench for mem_wb_stage, checked
// against a behavioural model; two instances cover the default and a 4-bit counter.
module tb_mem_wb_stage;

  logic        clock;
  logic        resetN;
  logic        stall;
  logic        flush;
  logic        validIn;
  logic [31:0] ALUResult;
  logic [31:0] readData;
  logic [4:0]  writeRegIn;
  logic        regWriteF;
  logic        memToRegF;

  logic [31:0] writeDataA, writeDataB;
  logic [4:0]  writeRegA, writeRegB;
  logic        regWriteA, regWriteB;
  logic        validA, validB;
  logic [15:0] countA;
  logic [3:0]  countB;

  int compareCount;
  int mismatchCount;

  // Behavioural model of the write-back slot
  logic        mValid;
  logic        mRegWrite;
  logic [31:0] mData;
  logic [4:0]  mReg;
  int          mRetired;

  mem_wb_stage #(.CNT_W(16)) dutWide (
    .clock(clock), .resetN(resetN), .stall(stall), .flush(flush),
    .validIn(validIn), .ALUResult(ALUResult), .readData(readData),
    .writeRegIn(writeRegIn), .regWriteF(regWriteF), .memToRegF(memToRegF),
    .writeData(writeDataA), .writeRegOut(writeRegA), .regWriteOut(regWriteA),
    .validOut(validA), .retiredCount(countA)
  );

  mem_wb_stage #(.CNT_W(4)) dutNarrow (
    .clock(clock), .resetN(resetN), .stall(stall), .flush(flush),
    .validIn(validIn), .ALUResult(ALUResult), .readData(readData),
    .writeRegIn(writeRegIn), .regWriteF(regWriteF), .memToRegF(memToRegF),
    .writeData(writeDataB), .writeRegOut(writeRegB), .regWriteOut(regWriteB),
    .validOut(validB), .retiredCount(countB)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mValid    = 1'b0;
    mRegWrite = 1'b0;
    mData     = 32'd0;
    mReg      = 5'd0;
    mRetired  = 0;
  endtask

  // One clock edge as the pipeline sees it: flush beats stall beats load
  task automatic modelEdge();
    if (flush) begin
      mValid    = 1'b0;
      mRegWrite = 1'b0;
      mData     = 32'd0;
      mReg      = 5'd0;
    end else if (!stall) begin
      mValid    = validIn;
      mRegWrite = validIn && regWriteF && (writeRegIn != 5'd0);
      mData     = memToRegF ? readData : ALUResult;
      mReg      = writeRegIn;
      if (validIn) mRetired++;
    end
  endtask

  task automatic checkAll(input string tag);
    int sat16;
    int sat4;
    sat16 = (mRetired > 65535) ? 65535 : mRetired;
    sat4  = (mRetired > 15) ? 15 : mRetired;
    checkOutput({tag, ".writeData"},   writeDataA, mData);
    checkOutput({tag, ".writeReg"},    {27'd0, writeRegA}, {27'd0, mReg});
    checkOutput({tag, ".regWrite"},    {31'd0, regWriteA}, {31'd0, mRegWrite});
    checkOutput({tag, ".valid"},       {31'd0, validA}, {31'd0, mValid});
    checkOutput({tag, ".count16"},     {16'd0, countA}, sat16);
    checkOutput({tag, ".count4"},      {28'd0, countB}, sat4);
    checkOutput({tag, ".narrowData"},  writeDataB, mData);
    checkOutput({tag, ".narrowRegWr"}, {31'd0, regWriteB}, {31'd0, mRegWrite});
    checkOutput({tag, ".narrowValid"}, {31'd0, validB}, {31'd0, mValid});
    checkOutput({tag, ".narrowReg"},   {27'd0, writeRegB}, {27'd0, mReg});
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic vi,
                               input logic [31:0] alu, input logic [31:0] rd,
                               input logic [4:0] wr, input logic rw, input logic m2r,
                               input string tag);
    stall      = st;
    flush      = fl;
    validIn    = vi;
    ALUResult  = alu;
    readData   = rd;
    writeRegIn = wr;
    regWriteF  = rw;
    memToRegF  = m2r;
    @(posedge clock);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, ".writeData"}, writeDataA, 32'd0);
    checkOutput({tag, ".writeReg"},  {27'd0, writeRegA}, 32'd0);
    checkOutput({tag, ".regWrite"},  {31'd0, regWriteA}, 32'd0);
    checkOutput({tag, ".valid"},     {31'd0, validA}, 32'd0);
    checkOutput({tag, ".count16"},   {16'd0, countA}, 32'd0);
    checkOutput({tag, ".count4"},    {28'd0, countB}, 32'd0);
  endtask

  // Assert reset between edges with random inputs; outputs must clear at once
  task automatic resetMidCycle(input string tag);
    #3;
    stall      = 1'($urandom);
    flush      = 1'($urandom);
    validIn    = 1'b1;
    ALUResult  = $urandom;
    readData   = $urandom;
    writeRegIn = 5'($urandom_range(1, 31));
    regWriteF  = 1'b1;
    memToRegF  = 1'($urandom);
    resetN     = 1'b0;
    #1;
    modelReset();
    checkZeroOutputs(tag);
    @(posedge clock);
    #1;
    checkZeroOutputs({tag, ".held"});
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic randomStep(input string tag);
    logic [4:0] wr;
    wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) != 0, $urandom, $urandom, wr,
                  1'($urandom), 1'($urandom), tag);
  endtask

  // Main sequence: reset, directed cases, random traffic, saturation
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    resetN     = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    validIn    = 1'b0;
    ALUResult  = 32'd0;
    readData   = 32'd0;
    writeRegIn = 5'd0;
    regWriteF  = 1'b0;
    memToRegF  = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkZeroOutputs("powerOnReset");
    @(negedge clock);
    resetN = 1'b1;

    // ALU write-back
    applyStimulus(0, 0, 1, 32'h0000_002A, 32'h1234_5678, 5'd8, 1, 0, "aluWb");
    checkOutput("aluWb.const.data", writeDataA, 32'h2A);
    checkOutput("aluWb.const.reg", {27'd0, writeRegA}, 32'd8);
    checkOutput("aluWb.const.regWrite", {31'd0, regWriteA}, 32'd1);
    checkOutput("aluWb.const.count", {16'd0, countA}, 32'd1);

    // Load write-back, then the same to $zero
    applyStimulus(0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9, 1, 1, "loadWb");
    checkOutput("loadWb.const.data", writeDataA, 32'hDEAD_BEEF);
    checkOutput("loadWb.const.regWrite", {31'd0, regWriteA}, 32'd1);
    applyStimulus(0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1, 1, "zeroReg");
    checkOutput("zeroReg.const.regWrite", {31'd0, regWriteA}, 32'd0);
    checkOutput("zeroReg.const.count", {16'd0, countA}, 32'd3);

    // Bubble loads but never writes nor counts
    applyStimulus(0, 0, 0, 32'h5555_0000, 32'h0, 5'd3, 1, 0, "bubble");

    // Stall holds through three edges, then stall+flush empties the slot
    applyStimulus(0, 0, 1, 32'hCAFE_0005, 32'h0, 5'd5, 1, 0, "loadReg5");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, $urandom, $urandom, 5'd17, 1, 1, "stallHold");
    end
    checkOutput("stallHold.const.data", writeDataA, 32'hCAFE_0005);
    checkOutput("stallHold.const.count", {16'd0, countA}, 32'd4);
    applyStimulus(1, 1, 1, $urandom, $urandom, 5'd17, 1, 1, "stallFlush");
    checkOutput("stallFlush.const.valid", {31'd0, validA}, 32'd0);
    checkOutput("stallFlush.const.regWrite", {31'd0, regWriteA}, 32'd0);
    checkOutput("stallFlush.const.data", writeDataA, 32'd0);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 300; i++) begin
      randomStep("random");
      if (i == 150) resetMidCycle("midReset");
    end

    // Saturation of the 4-bit counter: 20 valid interleaved with 5 bubbles
    resetMidCycle("preSat");
    for (int i = 0; i < 25; i++) begin
      applyStimulus(0, 0, (i % 5) != 4, $urandom, $urandom,
                    5'($urandom_range(1, 31)), 1, 1'($urandom), "saturate");
    end
    checkOutput("saturate.const.count4", {28'd0, countB}, 32'hF);
    checkOutput("saturate.const.count16", {16'd0, countA}, 32'd20);
    applyStimulus(0, 0, 1, $urandom, $urandom, 5'd4, 1, 0, "saturateHold");
    checkOutput("saturateHold.const.count4", {28'd0, countB}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
